keypad_controlador_senha: RTL and testbench

//  Password-lock controller that sits downstream of the 4x4 keypad decoder. It consumes the

---
 rtl/keypad_controlador_senha_pkg.sv | 50 +++++
 rtl/keypad_controlador_senha_if.sv | 24 ++
 rtl/keypad_controlador_senha_qualificador.sv | 59 +++++
 rtl/keypad_controlador_senha.sv | 175 +++++++++++++++++
 tb/tb_keypad_controlador_senha.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_controlador_senha_pkg.sv
// rtl/keypad_controlador_senha_pkg.sv - key codes, FSM states and digit decode for the password lock
package keypad_controlador_senha_pkg;

  localparam logic [4:0] T_0    = 5'd0;
  localparam logic [4:0] T_1    = 5'd1;
  localparam logic [4:0] T_2    = 5'd2;
  localparam logic [4:0] T_3    = 5'd3;
  localparam logic [4:0] T_4    = 5'd4;
  localparam logic [4:0] T_5    = 5'd5;
  localparam logic [4:0] T_6    = 5'd6;
  localparam logic [4:0] T_7    = 5'd7;
  localparam logic [4:0] T_8    = 5'd8;
  localparam logic [4:0] T_9    = 5'd9;
  localparam logic [4:0] T_A    = 5'd10;
  localparam logic [4:0] T_B    = 5'd11;
  localparam logic [4:0] T_C    = 5'd12;
  localparam logic [4:0] T_D    = 5'd13;
  localparam logic [4:0] T_ASTE = 5'd14;
  localparam logic [4:0] T_HASH = 5'd15;
  localparam logic [4:0] T_NULL = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_PROGRAM = 3'd4,
    ST_ERROR   = 3'd5,
    ST_LOCKOUT = 3'd6
  } estado_t;

  typedef struct packed {
    logic       valido;
    logic [3:0] bcd;
  } digito_t;

  // Non-digit keys come back with valido = 0 and an out-of-range BCD value.
  function automatic digito_t tecla_para_bcd(input logic [4:0] tecla);
    digito_t r;
    if (tecla <= T_9) begin
      r.valido = 1'b1;
      r.bcd    = tecla[3:0];
    end else begin
      r.valido = 1'b0;
      r.bcd    = 4'hF;
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_controlador_senha_if.sv
// rtl/keypad_controlador_senha_if.sv - keypad key input and lock status bundle
interface keypad_controlador_senha_if #(
  parameter int N_DIGITS = 4
);
  logic [4:0]            key;
  logic                  key_valid;
  logic [4:0]            key_code;
  logic [4*N_DIGITS-1:0] digits;
  logic [3:0]            n_digits;
  logic                  aberto;
  logic                  erro;
  logic                  bloqueado;
  logic [2:0]            estado;

  modport master (
    output key,
    input  key_valid, key_code, digits, n_digits, aberto, erro, bloqueado, estado
  );

  modport slave (
    input  key,
    output key_valid, key_code, digits, n_digits, aberto, erro, bloqueado, estado
  );
endinterface

// File: rtl/keypad_controlador_senha_qualificador.sv
// rtl/keypad_controlador_senha_qualificador.sv - press/release handshake: one key_valid per stable press
module keypad_qualificador
  import keypad_controlador_senha_pkg::*;
#(
  parameter int HOLD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] key_i,
  output logic       key_valid_o,
  output logic [4:0] key_code_o
);
  localparam int            CW   = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD = CW'(HOLD_CYCLES);

  logic [4:0]    key_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q;
  logic          key_valid_q;
  logic [4:0]    key_code_q;
  logic          hit;

  // cnt_d is the run length of the current key value, saturating at HOLD.
  always_comb begin
    if (key_i != key_prev_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q == HOLD) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign hit = (cnt_d == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_prev_q  <= T_NULL;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= T_NULL;
    end else begin
      key_prev_q  <= key_i;
      cnt_q       <= cnt_d;
      key_valid_q <= 1'b0;
      if (hit && key_i == T_NULL) begin
        armed_q <= 1'b1;
      end else if (hit && armed_q) begin
        key_valid_q <= 1'b1;
        key_code_q  <= key_i;
        armed_q     <= 1'b0;
      end
    end
  end

  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;
endmodule

// File: rtl/keypad_controlador_senha.sv
// rtl/keypad_controlador_senha.sv - password lock: digit entry, code check, open/error/lockout timing
module keypad_controlador_senha
  import keypad_controlador_senha_pkg::*;
#(
  parameter int                  N_DIGITS    = 4,
  parameter int                  HOLD_CYCLES = 1000,
  parameter int                  OPEN_CYCLES = 50000000,
  parameter int                  ERR_CYCLES  = 25000000,
  parameter int                  MAX_TRIES   = 3,
  parameter int                  LOCK_CYCLES = 250000000,
  parameter logic [4*N_DIGITS-1:0] SENHA_RESET = 16'h1234
) (
  input logic                        clk,
  input logic                        rst_n,
  keypad_controlador_senha_if.slave  kp
);
  localparam int W       = 4 * N_DIGITS;
  localparam int MAX_CYC = (OPEN_CYCLES > ERR_CYCLES)
                         ? ((OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES)
                         : ((ERR_CYCLES > LOCK_CYCLES) ? ERR_CYCLES : LOCK_CYCLES);
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int RW      = $clog2(MAX_TRIES + 1);

  localparam logic [3:0]    N_FULL    = 4'(N_DIGITS);
  localparam logic [RW-1:0] TRIES_MAX = RW'(MAX_TRIES);
  localparam logic [TW-1:0] LD_OPEN   = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LD_ERR    = TW'(ERR_CYCLES - 1);
  localparam logic [TW-1:0] LD_LOCK   = TW'(LOCK_CYCLES - 1);

  logic          key_valid;
  logic [4:0]    key_code;
  digito_t       dig;
  estado_t       state_q, state_d;
  logic [W-1:0]  digits_q, digits_d, stored_q, stored_d, shifted;
  logic [3:0]    n_q, n_d;
  logic [RW-1:0] tries_q, tries_d, tries_inc;
  logic [TW-1:0] timer_q, timer_d;
  logic          aberto_q, erro_q, bloqueado_q;
  logic          full;

  keypad_qualificador #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_qualificador (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_i       (kp.key),
    .key_valid_o (key_valid),
    .key_code_o  (key_code)
  );

  assign dig       = tecla_para_bcd(key_code);
  assign shifted   = (digits_q << 4) | W'(dig.bcd);
  assign full      = (n_q == N_FULL);
  assign tries_inc = (tries_q >= TRIES_MAX) ? tries_q : tries_q + RW'(1);

  // Timers load on state entry and count down; zero in a timed state means expiry,
  // which is tested before key_valid so a coincident key is dropped.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    n_d      = n_q;
    stored_d = stored_q;
    tries_d  = tries_q;
    timer_d  = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
    case (state_q)
      ST_IDLE: begin
        if (key_valid && dig.valido) begin
          digits_d = W'(dig.bcd);
          n_d      = 4'd1;
          state_d  = ST_ENTRY;
        end
      end
      ST_ENTRY, ST_PROGRAM: begin
        if (key_valid) begin
          if (dig.valido) begin
            if (!full) begin
              digits_d = shifted;
              n_d      = n_q + 4'd1;
            end
          end else if (key_code == T_ASTE) begin
            digits_d = '0;
            n_d      = '0;
            state_d  = ST_IDLE;
          end else if (key_code == T_HASH) begin
            if (state_q == ST_PROGRAM) begin
              if (full) begin
                stored_d = digits_q;
                digits_d = '0;
                n_d      = '0;
                state_d  = ST_IDLE;
              end
            end else if (full) begin
              state_d = ST_CHECK;
            end else begin
              tries_d  = tries_inc;
              digits_d = '0;
              n_d      = '0;
              timer_d  = LD_ERR;
              state_d  = ST_ERROR;
            end
          end
        end
      end
      ST_CHECK: begin
        digits_d = '0;
        n_d      = '0;
        if (digits_q == stored_q) begin
          tries_d = '0;
          timer_d = LD_OPEN;
          state_d = ST_OPEN;
        end else begin
          tries_d = tries_inc;
          if (tries_inc >= TRIES_MAX) begin
            timer_d = LD_LOCK;
            state_d = ST_LOCKOUT;
          end else begin
            timer_d = LD_ERR;
            state_d = ST_ERROR;
          end
        end
      end
      ST_OPEN: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else if (key_valid && key_code == T_A) begin
          timer_d = '0;
          state_d = ST_PROGRAM;
        end
      end
      ST_ERROR: begin
        if (timer_q == '0) state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          tries_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      digits_q    <= '0;
      n_q         <= '0;
      stored_q    <= SENHA_RESET;
      tries_q     <= '0;
      timer_q     <= '0;
      aberto_q    <= 1'b0;
      erro_q      <= 1'b0;
      bloqueado_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      n_q         <= n_d;
      stored_q    <= stored_d;
      tries_q     <= tries_d;
      timer_q     <= timer_d;
      aberto_q    <= (state_d == ST_OPEN) || (state_d == ST_PROGRAM);
      erro_q      <= (state_d == ST_ERROR);
      bloqueado_q <= (state_d == ST_LOCKOUT);
    end
  end

  assign kp.key_valid = key_valid;
  assign kp.key_code  = key_code;
  assign kp.digits    = digits_q;
  assign kp.n_digits  = n_q;
  assign kp.aberto    = aberto_q;
  assign kp.erro      = erro_q;
  assign kp.bloqueado = bloqueado_q;
  assign kp.estado    = state_q;
endmodule

// File: tb/tb_keypad_controlador_senha.sv
// tb/tb_keypad_controlador_senha.sv - table, sequence and randomized checks of the password lock
module tb_keypad_controlador_senha;
  import keypad_controlador_senha_pkg::*;

  localparam int N      = 4;
  localparam int HOLD   = 4;
  localparam int OPEN_C = 20;
  localparam int ERR_C  = 10;
  localparam int TRIES  = 3;
  localparam int LOCK_C = 40;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  keypad_controlador_senha_if #(.N_DIGITS(N)) kp ();

  keypad_controlador_senha #(
    .N_DIGITS    (N),
    .HOLD_CYCLES (HOLD),
    .OPEN_CYCLES (OPEN_C),
    .ERR_CYCLES  (ERR_C),
    .MAX_TRIES   (TRIES),
    .LOCK_CYCLES (LOCK_C),
    .SENHA_RESET (16'h1234)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_kv, cnt_ab, cnt_er, cnt_bl;
  bit saw_check;

  // Reference: entered digits as a queue, key history window, absolute-cycle deadlines.
  estado_t    m_st;
  int         m_buf[$];
  int         m_hist[$];
  bit         m_armed;
  bit         m_kv;
  logic [4:0] m_kc;
  int         m_tries;
  int         m_stored;
  int         m_deadline;
  int         m_edge = 0;

  function automatic bit is_dig(input logic [4:0] k);
    return k <= T_9;
  endfunction

  function automatic int pack_buf();
    int v = 0;
    foreach (m_buf[i]) v = v * 16 + m_buf[i];
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got 0x%0h, want 0x%0h", nm, m_edge, act, exp);
    end
  endtask

  task automatic model_step(input logic [4:0] k, input logic r);
    bit         kv, all_eq;
    logic [4:0] kc;
    int         d;
    m_edge++;
    if (!r) begin
      m_st = ST_IDLE; m_buf.delete(); m_hist.delete(); m_armed = 0;
      m_kv = 0; m_kc = T_NULL; m_tries = 0; m_stored = 'h1234; m_deadline = 0;
      return;
    end
    kv = m_kv;
    kc = m_kc;
    d  = int'(kc);
    case (m_st)
      ST_IDLE: if (kv && is_dig(kc)) begin m_buf.push_back(d); m_st = ST_ENTRY; end
      ST_ENTRY, ST_PROGRAM: if (kv) begin
        if (is_dig(kc)) begin
          if (m_buf.size() < N) m_buf.push_back(d);
        end else if (kc == T_ASTE) begin
          m_buf.delete(); m_st = ST_IDLE;
        end else if (kc == T_HASH && m_st == ST_PROGRAM) begin
          if (m_buf.size() == N) begin m_stored = pack_buf(); m_buf.delete(); m_st = ST_IDLE; end
        end else if (kc == T_HASH) begin
          if (m_buf.size() == N) m_st = ST_CHECK;
          else begin
            m_tries = (m_tries + 1 > TRIES) ? TRIES : m_tries + 1;
            m_buf.delete(); m_st = ST_ERROR; m_deadline = m_edge + ERR_C;
          end
        end
      end
      ST_CHECK: begin
        if (pack_buf() == m_stored) begin
          m_tries = 0; m_st = ST_OPEN; m_deadline = m_edge + OPEN_C;
        end else begin
          m_tries = (m_tries + 1 > TRIES) ? TRIES : m_tries + 1;
          if (m_tries >= TRIES) begin m_st = ST_LOCKOUT; m_deadline = m_edge + LOCK_C; end
          else begin m_st = ST_ERROR; m_deadline = m_edge + ERR_C; end
        end
        m_buf.delete();
      end
      ST_OPEN: begin
        if (m_edge == m_deadline) m_st = ST_IDLE;
        else if (kv && kc == T_A) m_st = ST_PROGRAM;
      end
      ST_ERROR:   if (m_edge == m_deadline) m_st = ST_IDLE;
      ST_LOCKOUT: if (m_edge == m_deadline) begin m_tries = 0; m_st = ST_IDLE; end
      default: ;
    endcase
    m_hist.push_back(int'(k));
    if (m_hist.size() > HOLD) void'(m_hist.pop_front());
    all_eq = (m_hist.size() == HOLD);
    foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) all_eq = 0;
    m_kv = 0;
    if (all_eq && k == T_NULL) m_armed = 1;
    else if (all_eq && m_armed) begin m_kv = 1; m_kc = k; m_armed = 0; end
  endtask

  task automatic check_all();
    chk("key_valid", int'(kp.key_valid), int'(m_kv));
    chk("key_code",  int'(kp.key_code),  int'(m_kc));
    chk("digits",    int'(kp.digits),    pack_buf());
    chk("n_digits",  int'(kp.n_digits),  m_buf.size());
    chk("aberto",    int'(kp.aberto),    int'(m_st == ST_OPEN || m_st == ST_PROGRAM));
    chk("erro",      int'(kp.erro),      int'(m_st == ST_ERROR));
    chk("bloqueado", int'(kp.bloqueado), int'(m_st == ST_LOCKOUT));
    chk("estado",    int'(kp.estado),    int'(m_st));
  endtask

  task automatic tick(input logic [4:0] k);
    kp.key = k;
    @(posedge clk);
    model_step(k, rst_n);
    @(negedge clk);
    check_all();
    cnt_kv += int'(kp.key_valid);
    cnt_ab += int'(kp.aberto);
    cnt_er += int'(kp.erro);
    cnt_bl += int'(kp.bloqueado);
    if (kp.estado == ST_CHECK) saw_check = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(T_NULL);
  endtask

  task automatic press(input logic [4:0] k);
    repeat (6) tick(k);
    idle(6);
  endtask

  task automatic clr_counts();
    cnt_kv = 0; cnt_ab = 0; cnt_er = 0; cnt_bl = 0; saw_check = 0;
  endtask

  typedef struct {
    logic [4:0] k;
    int         n_exp;
    int         d_exp;
    estado_t    st_exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back('{T_1,    1, 'h0001, ST_ENTRY});
    tbl.push_back('{T_2,    2, 'h0012, ST_ENTRY});
    tbl.push_back('{T_ASTE, 0, 'h0000, ST_IDLE});
    tbl.push_back('{T_1,    1, 'h0001, ST_ENTRY});
    tbl.push_back('{T_2,    2, 'h0012, ST_ENTRY});
    tbl.push_back('{T_3,    3, 'h0123, ST_ENTRY});
    tbl.push_back('{T_4,    4, 'h1234, ST_ENTRY});
    tbl.push_back('{T_HASH, 0, 'h0000, ST_OPEN});
    tbl.push_back('{T_NULL, 0, 'h0000, ST_IDLE});
    tbl.push_back('{T_1,    1, 'h0001, ST_ENTRY});
    tbl.push_back('{T_2,    2, 'h0012, ST_ENTRY});
    tbl.push_back('{T_3,    3, 'h0123, ST_ENTRY});
    tbl.push_back('{T_4,    4, 'h1234, ST_ENTRY});
    tbl.push_back('{T_5,    4, 'h1234, ST_ENTRY});
    tbl.push_back('{T_HASH, 0, 'h0000, ST_OPEN});
    tbl.push_back('{T_A,    0, 'h0000, ST_PROGRAM});
    tbl.push_back('{T_4,    1, 'h0004, ST_PROGRAM});
    tbl.push_back('{T_3,    2, 'h0043, ST_PROGRAM});
    tbl.push_back('{T_2,    3, 'h0432, ST_PROGRAM});
    tbl.push_back('{T_1,    4, 'h4321, ST_PROGRAM});
    tbl.push_back('{T_HASH, 0, 'h0000, ST_IDLE});
    tbl.push_back('{T_1,    1, 'h0001, ST_ENTRY});
    tbl.push_back('{T_2,    2, 'h0012, ST_ENTRY});
    tbl.push_back('{T_3,    3, 'h0123, ST_ENTRY});
    tbl.push_back('{T_4,    4, 'h1234, ST_ENTRY});
    tbl.push_back('{T_HASH, 0, 'h0000, ST_ERROR});
    tbl.push_back('{T_NULL, 0, 'h0000, ST_IDLE});
    tbl.push_back('{T_4,    1, 'h0004, ST_ENTRY});
    tbl.push_back('{T_3,    2, 'h0043, ST_ENTRY});
    tbl.push_back('{T_2,    3, 'h0432, ST_ENTRY});
    tbl.push_back('{T_1,    4, 'h4321, ST_ENTRY});
    tbl.push_back('{T_HASH, 0, 'h0000, ST_OPEN});
    tbl.push_back('{T_NULL, 0, 'h0000, ST_IDLE});

    clr_counts();
    rst_n  = 1'b0;
    kp.key = T_NULL;
    tick(T_NULL);
    tick(T_NULL);
    chk("rst key_valid", int'(kp.key_valid), 0);
    chk("rst key_code",  int'(kp.key_code),  int'(T_NULL));
    chk("rst digits",    int'(kp.digits),    0);
    chk("rst aberto",    int'(kp.aberto) + int'(kp.erro) + int'(kp.bloqueado), 0);
    chk("rst estado",    int'(kp.estado),    0);
    rst_n = 1'b1;
    idle(6);

    clr_counts();
    press(T_1); press(T_2); press(T_3); press(T_4); press(T_HASH);
    idle(30);
    chk("t1 key_valid count", cnt_kv, 5);
    chk("t1 check seen", int'(saw_check), 1);
    chk("t1 aberto cycles", cnt_ab, 20);

    clr_counts();
    repeat (10) tick(T_5);
    idle(2);
    repeat (18) tick(T_5);
    idle(6);
    chk("t2 glitch key_valid count", cnt_kv, 1);
    chk("t2 n_digits", int'(kp.n_digits), 1);
    clr_counts();
    repeat (2) tick(T_7);
    idle(6);
    chk("t2 short press key_valid", cnt_kv, 0);
    press(T_ASTE);

    clr_counts();
    for (int r = 0; r < 3; r++) begin
      repeat (4) press(T_9);
      press(T_HASH);
      if (r < 2) idle(12);
    end
    press(T_1);
    chk("t3 lockout ignores key", int'(kp.n_digits), 0);
    chk("t3 bloqueado mid", int'(kp.bloqueado), 1);
    idle(30);
    chk("t3 erro cycles", cnt_er, 20);
    chk("t3 bloqueado cycles", cnt_bl, 40);
    chk("t3 back to idle", int'(kp.estado), int'(ST_IDLE));

    foreach (tbl[i]) begin
      if (tbl[i].k == T_NULL) idle(25);
      else press(tbl[i].k);
      chk($sformatf("tbl%0d n_digits", i), int'(kp.n_digits), tbl[i].n_exp);
      chk($sformatf("tbl%0d digits", i),   int'(kp.digits),   tbl[i].d_exp);
      chk($sformatf("tbl%0d estado", i),   int'(kp.estado),   int'(tbl[i].st_exp));
    end

    press(T_4); press(T_3); press(T_2); press(T_1); press(T_HASH);
    press(T_A); press(T_4); press(T_3);
    chk("t6 in program", int'(kp.estado), int'(ST_PROGRAM));
    rst_n = 1'b0;
    tick(T_2);
    rst_n = 1'b1;
    chk("t6 rst aberto",   int'(kp.aberto),   0);
    chk("t6 rst n_digits", int'(kp.n_digits), 0);
    chk("t6 rst key_code", int'(kp.key_code), int'(T_NULL));
    chk("t6 rst estado",   int'(kp.estado),   0);
    clr_counts();
    repeat (10) tick(T_2);
    idle(6);
    chk("t6 held key after reset", cnt_kv, 0);
    press(T_1); press(T_2); press(T_3); press(T_4); press(T_HASH);
    chk("t6 reset code unlocks", int'(kp.aberto), 1);
    idle(25);

    for (int i = 0; i < 250; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 2) begin
        rst_n = 1'b0;
        tick(5'($urandom_range(0, 15)));
        rst_n = 1'b1;
        idle(6);
      end else if (sel < 15) begin
        for (int j = N - 1; j >= 0; j--) press(5'((m_stored >> (4 * j)) & 15));
        press(T_HASH);
      end else begin
        logic [4:0] k;
        k = 5'($urandom_range(0, 15));
        repeat ($urandom_range(1, 8)) tick(k);
        repeat ($urandom_range(1, 8)) tick(T_NULL);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
